modulo_updown_counter: RTL
==========================

// Module: modulo_updown_counter
// PURPOSE
//  Parametrised up/down counter with load, programmable modulus and wrap/saturate mode.
//  Consumes one count per four-phase up/down request, e.g. from a button-press detector.
//  Sits between the request sources and the display/LED outputs.
//  Chainable as decade digits when cascade outputs are compiled in.
// PARAMETERS
//  SIZE      4    counter width in bits
//  MODULUS   16   count range 0..MODULUS-1; 2 <= MODULUS <= 2**SIZE
//  SATURATE  0    0 = wrap at range ends, 1 = hold at 0 / MODULUS-1
// PORTS
//  clock     in   1     count clock (slow, e.g. prescaled 1 kHz)
//  reset     in   1     asynchronous, active-high; clears all state
//  up        in   1     count-up request; held high until upAck, then released
//  down      in   1     count-down request; same protocol as up
//  load      in   1     synchronous load, level-sensitive
//  data      in   SIZE  load value
//  upAck     out  1     acknowledge for up
//  downAck   out  1     acknowledge for down
//  counter   out  SIZE  current count
//  atMax     out  1     counter == MODULUS-1 (combinational from counter)
//  atMin     out  1     counter == 0 (combinational from counter)
// BEHAVIOUR
//  - Reset (async): counter=0, upAck=0, downAck=0; atMin=1, atMax=0. Deassertion takes effect at the next clock edge.
//  - Handshake per channel (four-phase), registered ack:
//    - Ack FSM states are IDLE(ack=0) and ACKED(ack=1).
//    - IDLE & req=1 -> ACKED; exactly one count step on that edge.
//    - ACKED & req=0 -> IDLE.
//    - A req held high in ACKED causes no further steps.
//  - Latency: request sampled high at edge N -> counter and ack update at edge N.
//    - Both are visible one clock after req rises.
//  - Priority per edge: load > count.
//    - load=1: counter = (data > MODULUS-1) ? MODULUS-1 : data.
//    - Pending requests are still acked while load=1, but their steps are discarded.
//  - Step in the same edge for both channels, i.e. up and down both IDLE->ACKED:
//    - net step is zero; counter unchanged; both acks assert.
//  - Up step at MODULUS-1: wraps to 0 (SATURATE=0) or holds (SATURATE=1).
//  - Down step at 0: wraps to MODULUS-1 (SATURATE=0) or holds (SATURATE=1).
//    - In both saturate cases the request is still acked.
//  - The counter never holds a value >= MODULUS.
//  - Arithmetic is done in SIZE+1 bits; the comparison with MODULUS happens before truncation.
//  - Reset mid-handshake: ack drops immediately.
//    - A request still high after reset is treated as new and counts once.
// CONFIGURATION
//  - `define MODCNT_CASCADE_EN adds two outputs:
//    - carryOut  out 1: one-clock pulse on the edge where an up step wraps MODULUS-1 -> 0.
//    - borrowOut out 1: one-clock pulse on the edge where a down step wraps 0 -> MODULUS-1.
//    - Both reset to 0.
//    - Both are never asserted when SATURATE=1 or on a load.
//    - The pulses are intended to drive the next digit's up/down.
//      Because the next digit's ack is ignored, the pulse must be exactly 1 cycle, then low for at least 1 cycle.
//  - Without the macro these ports do not exist and no cascade logic is synthesised.
// TESTING
//  - Reset mid-count, SIZE=4, MODULUS=10, counter=7, upAck=1: assert reset asynchronously
//    -> counter=0, upAck=0 before the next edge; atMin=1.
//  - Handshake: up held high 5 cycles from counter=3 -> counter=4 after the first edge only; upAck=1 until up drops, then 0 one edge later.
//  - Wrap (SATURATE=0, MODULUS=10): 10 up requests from 0 -> 1,2,..,9,0.
//    - With MODCNT_CASCADE_EN: carryOut pulses once on the 9->0 edge.
//  - Saturate (SATURATE=1): down request at 0 -> counter stays 0, downAck=1, no borrowOut.
//  - Load: data=4'hF, MODULUS=10, load=1 together with a new up request
//    -> counter=9, upAck=1; after releasing up, no step occurs.
//  - Simultaneous: up and down rise on the same cycle at counter=5 -> counter=5, upAck=downAck=1.

Source files
------------

// File: rtl/modulo_updown_counter.sv
// -----------------------------------------------------------------------------
// modulo_updown_counter
//
// Purpose:
//   Up/down counter over the range 0..MODULUS-1 with synchronous load and
//   either wrap-around or saturation at the range ends. Each up/down request
//   is a four-phase handshake (req high -> ack high -> req low -> ack low),
//   and each handshake produces exactly one count step.
//
// Optional feature:
//   `define MODCNT_CASCADE_EN adds carryOut/borrowOut, one-clock pulses on an
//   up wrap (MODULUS-1 -> 0) or a down wrap (0 -> MODULUS-1). They are meant
//   to drive the up/down inputs of the next digit in a chain. Without the
//   macro the ports and their logic are absent.
//
// Ports:
//   clock     in   1     count clock
//   reset     in   1     asynchronous, active-high; clears all state
//   up        in   1     count-up request, held until upAck
//   down      in   1     count-down request, held until downAck
//   load      in   1     synchronous load, level-sensitive, wins over counting
//   data      in   SIZE  load value (clamped to MODULUS-1)
//   upAck     out  1     registered acknowledge for up
//   downAck   out  1     registered acknowledge for down
//   counter   out  SIZE  current count
//   atMax     out  1     counter == MODULUS-1
//   atMin     out  1     counter == 0
//   carryOut  out  1     (MODCNT_CASCADE_EN only) up-wrap pulse
//   borrowOut out  1     (MODCNT_CASCADE_EN only) down-wrap pulse
//
// Handshake semantics (both channels): a step is taken on the edge where the
// request is sampled high while the channel FSM is IDLE; that same edge moves
// the FSM to ACKED, raising the ack. The FSM returns to IDLE on the first edge
// that samples the request low. A request held high in ACKED does nothing.
// -----------------------------------------------------------------------------
module modulo_updown_counter #(
  parameter int SIZE     = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            up,
  input  logic            down,
  input  logic            load,
  input  logic [SIZE-1:0] data,
  output logic            upAck,
  output logic            downAck,
  output logic [SIZE-1:0] counter,
  output logic            atMax,
  output logic            atMin
`ifdef MODCNT_CASCADE_EN
  ,
  output logic            carryOut,
  output logic            borrowOut
`endif
);

  // Range limits kept one bit wider than the counter so MODULUS == 2**SIZE
  // is representable and the wrap test happens before truncation.
  localparam logic [SIZE:0]   MOD_EXT  = (SIZE+1)'(MODULUS);
  localparam logic [SIZE:0]   LAST_EXT = MOD_EXT - 1'b1;
  localparam logic [SIZE-1:0] MAX_VAL  = LAST_EXT[SIZE-1:0];

  typedef enum logic {
    IDLE  = 1'b0,
    ACKED = 1'b1
  } ack_state_t;

  // Both channel FSMs grouped so the pair can be observed as one signal.
  typedef struct packed {
    ack_state_t up_st;
    ack_state_t down_st;
  } ack_fsm_t;

  ack_fsm_t        fsm_q;
  ack_fsm_t        fsm_d;
  logic            up_step;
  logic            down_step;
  logic [SIZE:0]   inc_ext;
  logic [SIZE:0]   dec_ext;
  logic            up_wrap;
  logic            down_wrap;
  logic [SIZE-1:0] load_val;
  logic [SIZE-1:0] counter_d;

  // ---------------------------------------------------------------------------
  // Handshake FSMs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q.up_st   <= IDLE;
      fsm_q.down_st <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    up_step   = 1'b0;
    down_step = 1'b0;

    case (fsm_q.up_st)
      IDLE: begin
        if (up) begin
          fsm_d.up_st = ACKED;
          up_step     = 1'b1;
        end
      end
      ACKED: begin
        if (!up) fsm_d.up_st = IDLE;
      end
      default: fsm_d.up_st = IDLE;
    endcase

    case (fsm_q.down_st)
      IDLE: begin
        if (down) begin
          fsm_d.down_st = ACKED;
          down_step     = 1'b1;
        end
      end
      ACKED: begin
        if (!down) fsm_d.down_st = IDLE;
      end
      default: fsm_d.down_st = IDLE;
    endcase
  end

  assign upAck   = (fsm_q.up_st == ACKED);
  assign downAck = (fsm_q.down_st == ACKED);

  // ---------------------------------------------------------------------------
  // Count datapath
  // ---------------------------------------------------------------------------
  assign inc_ext   = {1'b0, counter} + 1'b1;
  assign dec_ext   = {1'b0, counter} - 1'b1;
  assign up_wrap   = (inc_ext >= MOD_EXT);
  // Borrow out of the extra top bit means the counter was 0.
  assign down_wrap = dec_ext[SIZE];
  assign load_val  = ({1'b0, data} > LAST_EXT) ? MAX_VAL : data;

  always_comb begin
    counter_d = counter;
    if (load) begin
      // Pending requests are still acked by the FSMs, but their steps are lost.
      counter_d = load_val;
    end else if (up_step && !down_step) begin
      if (up_wrap) begin
        if (SATURATE == 0) counter_d = '0;
      end else begin
        counter_d = inc_ext[SIZE-1:0];
      end
    end else if (down_step && !up_step) begin
      if (down_wrap) begin
        if (SATURATE == 0) counter_d = MAX_VAL;
      end else begin
        counter_d = dec_ext[SIZE-1:0];
      end
    end
    // Simultaneous up and down steps cancel: counter_d keeps its default.
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter <= '0;
    end else begin
      counter <= counter_d;
    end
  end

  assign atMax = (counter == MAX_VAL);
  assign atMin = (counter == '0);

`ifdef MODCNT_CASCADE_EN
  // ---------------------------------------------------------------------------
  // Cascade pulses. Successive steps on one channel are at least two edges
  // apart (the FSM must pass through IDLE), so each pulse is one clock wide
  // and followed by at least one low clock.
  // ---------------------------------------------------------------------------
  logic carry_d;
  logic borrow_d;

  assign carry_d  = (SATURATE == 0) && !load && up_step && !down_step && up_wrap;
  assign borrow_d = (SATURATE == 0) && !load && down_step && !up_step && down_wrap;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      carryOut  <= 1'b0;
      borrowOut <= 1'b0;
    end else begin
      carryOut  <= carry_d;
      borrowOut <= borrow_d;
    end
  end
`endif

endmodule
